bomb_put_ctrl: RTL and testbench

- Initiator side of the bomb-placement interface: turns raw player fire buttons into the single-cycle `p1_put`/`p2_put` + coordinate requests consumed by the bomb tile manager.
- Enforces capacity, cell-occupancy, same-cell arbitration and cooldown.
- Confirms each request by watching the tile map for the bomb to appear.
- Sits between the player input/movement logic and the bomb tile manager, clocked by the 30 Hz game tick.

---
 rtl/game_pkg.sv | 48 ++++
 rtl/put_chan.sv | 143 ++++++++++++++
 rtl/bomb_put_ctrl.sv | 94 +++++++++
 tb/tb_bomb_put_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the bomb-placement logic.
//   - tile state encodings stored in the 3-bit-per-cell tile map
//   - player identifiers
//   - rejection reason codes reported by the put channels
//   - put channel FSM states
//   - tile_at(): extract one cell's tile state from the flattened map
package game_pkg;

    localparam int unsigned TILE_W     = 3;
    localparam int unsigned GRID_CELLS = 256;

    localparam logic [2:0] EMPTY   = 3'd0;
    localparam logic [2:0] BLOCK   = 3'd1;
    localparam logic [2:0] BOMB_UN = 3'd2;
    localparam logic [2:0] BOMB_EX = 3'd3;
    localparam logic [2:0] EXP_H   = 3'd4;
    localparam logic [2:0] EXP_V   = 3'd5;
    localparam logic [2:0] EXP_END = 3'd6;
    localparam logic [2:0] EXP_CEN = 3'd7;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_t;

    typedef enum logic [1:0] {
        REJ_CAP = 2'd0,
        REJ_OCC = 2'd1,
        REJ_ARB = 2'd2,
        REJ_TMO = 2'd3
    } rej_code_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_COOLDOWN = 3'd4
    } put_state_t;

    function automatic logic [TILE_W-1:0] tile_at(
        input logic [TILE_W*GRID_CELLS-1:0] flat,
        input logic [7:0]                   idx
    );
        return flat[TILE_W*int'(idx) +: TILE_W];
    endfunction

endpackage

// File: rtl/put_chan.sv
// One bomb-put channel: button edge detect, request FSM, ack timeout,
// cooldown and confirmed-put counter.
//   clk, reset_n   game tick clock, async active-low reset
//   btn            fire button level
//   cor            current player cell
//   bomb_cap       bombs allowed on the grid
//   bomb_num       live bomb count
//   tile           tile state at the latched coordinate (put_cor)
//   lose_arb       other channel wins the same-cell tie this cycle
//   issue          channel is in ISSUE (for the arbiter)
//   put/put_cor    one-cycle placement request and its coordinate
//   reject/rej_code one-cycle rejection and its reason
//   busy           channel not IDLE
//   put_cnt        confirmed puts, saturating at 15
module put_chan
    import game_pkg::*;
#(
    parameter int unsigned COOLDOWN_CYC = 15,
    parameter int unsigned ACK_TIMEOUT  = 4,
    parameter int unsigned MAX_CAP      = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn,
    input  logic [7:0] cor,
    input  logic [2:0] bomb_cap,
    input  logic [2:0] bomb_num,
    input  logic [2:0] tile,
    input  logic       lose_arb,
    output logic       issue,
    output logic       put,
    output logic [7:0] put_cor,
    output logic       reject,
    output logic [1:0] rej_code,
    output logic       busy,
    output logic [3:0] put_cnt
);

    // A zero-length cooldown/timeout still spends one cycle in its state.
    localparam logic [7:0] CD_LAST = (COOLDOWN_CYC == 0) ? 8'd0 : 8'(COOLDOWN_CYC - 1);
    localparam logic [7:0] TO_LAST = (ACK_TIMEOUT == 0)  ? 8'd0 : 8'(ACK_TIMEOUT - 1);

    put_state_t state, state_nx;
    logic       btn_q;
    logic [7:0] cnt, cnt_nx;
    logic [7:0] cor_nx;
    logic       put_nx, reject_nx;
    rej_code_t  code_nx;
    logic [3:0] put_cnt_nx;
    logic [2:0] eff_cap;

    assign eff_cap = (bomb_cap > 3'(MAX_CAP)) ? 3'(MAX_CAP) : bomb_cap;
    assign issue   = (state == ST_ISSUE);
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            btn_q    <= 1'b0;
            cnt      <= '0;
            put_cor  <= '0;
            put      <= 1'b0;
            reject   <= 1'b0;
            rej_code <= '0;
            put_cnt  <= '0;
        end else begin
            state    <= state_nx;
            btn_q    <= btn;
            cnt      <= cnt_nx;
            put_cor  <= cor_nx;
            put      <= put_nx;
            reject   <= reject_nx;
            rej_code <= code_nx;
            put_cnt  <= put_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        cor_nx     = put_cor;
        put_nx     = 1'b0;
        reject_nx  = 1'b0;
        code_nx    = REJ_CAP;
        put_cnt_nx = put_cnt;
        case (state)
            ST_IDLE: begin
                if (btn && !btn_q) begin
                    state_nx = ST_CHECK;
                    cor_nx   = cor;
                end
            end
            ST_CHECK: begin
                if (bomb_num >= eff_cap) begin
                    reject_nx = 1'b1;
                    code_nx   = REJ_CAP;
                    state_nx  = ST_IDLE;
                end else if (tile != EMPTY) begin
                    reject_nx = 1'b1;
                    code_nx   = REJ_OCC;
                    state_nx  = ST_IDLE;
                end else begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (lose_arb) begin
                    reject_nx = 1'b1;
                    code_nx   = REJ_ARB;
                    state_nx  = ST_IDLE;
                end else begin
                    put_nx   = 1'b1;
                    cnt_nx   = '0;
                    state_nx = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (tile == BOMB_UN) begin
                    if (put_cnt != 4'hF) put_cnt_nx = put_cnt + 4'd1;
                    cnt_nx   = '0;
                    state_nx = ST_COOLDOWN;
                end else if (cnt >= TO_LAST) begin
                    reject_nx = 1'b1;
                    code_nx   = REJ_TMO;
                    cnt_nx    = '0;
                    state_nx  = ST_COOLDOWN;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            ST_COOLDOWN: begin
                if (cnt >= CD_LAST) begin
                    cnt_nx   = '0;
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/bomb_put_ctrl.sv
// Bomb-placement initiator for both players. Holds the tile-map lookups at
// each channel's latched coordinate and the same-cell arbitration (P1 wins).
//   clk, reset_n                 game tick clock, async active-low reset
//   px_btn, px_cor               fire button level and player cell
//   px_bomb_cap, bomb_num_px     capacity and live bomb count
//   bomb_tile_flat               3-bit-per-cell tile map
//   px_put, px_put_cor           placement request and coordinate
//   px_reject, px_rej_code       rejection pulse and reason
//   px_busy, px_put_cnt          channel activity and confirmed put count
module bomb_put_ctrl
    import game_pkg::*;
#(
    parameter int unsigned COOLDOWN_CYC = 15,
    parameter int unsigned ACK_TIMEOUT  = 4,
    parameter int unsigned MAX_CAP      = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         p1_btn,
    input  logic         p2_btn,
    input  logic [7:0]   p1_cor,
    input  logic [7:0]   p2_cor,
    input  logic [2:0]   p1_bomb_cap,
    input  logic [2:0]   p2_bomb_cap,
    input  logic [2:0]   bomb_num_p1,
    input  logic [2:0]   bomb_num_p2,
    input  logic [767:0] bomb_tile_flat,
    output logic         p1_put,
    output logic         p2_put,
    output logic [7:0]   p1_put_cor,
    output logic [7:0]   p2_put_cor,
    output logic         p1_reject,
    output logic         p2_reject,
    output logic [1:0]   p1_rej_code,
    output logic [1:0]   p2_rej_code,
    output logic         p1_busy,
    output logic         p2_busy,
    output logic [3:0]   p1_put_cnt,
    output logic [3:0]   p2_put_cnt
);

    logic [2:0] p1_tile, p2_tile;
    logic       p1_issue, p2_issue;
    logic       p2_lose;

    assign p1_tile = tile_at(bomb_tile_flat, p1_put_cor);
    assign p2_tile = tile_at(bomb_tile_flat, p2_put_cor);
    assign p2_lose = p1_issue && p2_issue && (p1_put_cor == p2_put_cor);

    put_chan #(
        .COOLDOWN_CYC (COOLDOWN_CYC),
        .ACK_TIMEOUT  (ACK_TIMEOUT),
        .MAX_CAP      (MAX_CAP)
    ) u_p1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn      (p1_btn),
        .cor      (p1_cor),
        .bomb_cap (p1_bomb_cap),
        .bomb_num (bomb_num_p1),
        .tile     (p1_tile),
        .lose_arb (1'b0),
        .issue    (p1_issue),
        .put      (p1_put),
        .put_cor  (p1_put_cor),
        .reject   (p1_reject),
        .rej_code (p1_rej_code),
        .busy     (p1_busy),
        .put_cnt  (p1_put_cnt)
    );

    put_chan #(
        .COOLDOWN_CYC (COOLDOWN_CYC),
        .ACK_TIMEOUT  (ACK_TIMEOUT),
        .MAX_CAP      (MAX_CAP)
    ) u_p2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn      (p2_btn),
        .cor      (p2_cor),
        .bomb_cap (p2_bomb_cap),
        .bomb_num (bomb_num_p2),
        .tile     (p2_tile),
        .lose_arb (p2_lose),
        .issue    (p2_issue),
        .put      (p2_put),
        .put_cor  (p2_put_cor),
        .reject   (p2_reject),
        .rej_code (p2_rej_code),
        .busy     (p2_busy),
        .put_cnt  (p2_put_cnt)
    );

endmodule

// File: tb/tb_bomb_put_ctrl.sv
// Directed bench for bomb_put_ctrl: a vector table of single P1 presses plus
// hand-written sequences for arbitration, timeout, held button, cooldown,
// reset abort and counter saturation.
module tb_bomb_put_ctrl;

    logic         clk;
    logic         reset_n;
    logic         p1_btn, p2_btn;
    logic [7:0]   p1_cor, p2_cor;
    logic [2:0]   p1_bomb_cap, p2_bomb_cap;
    logic [2:0]   bomb_num_p1, bomb_num_p2;
    logic [767:0] tiles;
    logic         p1_put, p2_put;
    logic [7:0]   p1_put_cor, p2_put_cor;
    logic         p1_reject, p2_reject;
    logic [1:0]   p1_rej_code, p2_rej_code;
    logic         p1_busy, p2_busy;
    logic [3:0]   p1_put_cnt, p2_put_cnt;

    int checks   = 0;
    int failures = 0;

    bomb_put_ctrl #(
        .COOLDOWN_CYC (15),
        .ACK_TIMEOUT  (4),
        .MAX_CAP      (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .p1_btn         (p1_btn),
        .p2_btn         (p2_btn),
        .p1_cor         (p1_cor),
        .p2_cor         (p2_cor),
        .p1_bomb_cap    (p1_bomb_cap),
        .p2_bomb_cap    (p2_bomb_cap),
        .bomb_num_p1    (bomb_num_p1),
        .bomb_num_p2    (bomb_num_p2),
        .bomb_tile_flat (tiles),
        .p1_put         (p1_put),
        .p2_put         (p2_put),
        .p1_put_cor     (p1_put_cor),
        .p2_put_cor     (p2_put_cor),
        .p1_reject      (p1_reject),
        .p2_reject      (p2_reject),
        .p1_rej_code    (p1_rej_code),
        .p2_rej_code    (p2_rej_code),
        .p1_busy        (p1_busy),
        .p2_busy        (p2_busy),
        .p1_put_cnt     (p1_put_cnt),
        .p2_put_cnt     (p2_put_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_tile(input logic [7:0] idx, input logic [2:0] v);
        tiles[int'(idx)*3 +: 3] = v;
    endtask

    // put/reject exclusivity and one-cycle pulse width, every cycle
    logic p1_put_d = 1'b0, p2_put_d = 1'b0, p1_rej_d = 1'b0, p2_rej_d = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            chk("pulse_rules",
                {30'd0,
                 (p1_put & p1_reject) | (p2_put & p2_reject),
                 (p1_put & p1_put_d) | (p2_put & p2_put_d) |
                 (p1_reject & p1_rej_d) | (p2_reject & p2_rej_d)}, 32'd0);
        end
        p1_put_d = p1_put; p2_put_d = p2_put;
        p1_rej_d = p1_reject; p2_rej_d = p2_reject;
    end

    task automatic wait_idle(input string nm, input int bound);
        int cyc;
        cyc = 0;
        while ((p1_busy || p2_busy) && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        chk(nm, {30'd0, p1_busy, p2_busy}, 32'd0);
    endtask

    // press P1 at cell c, check the put at +2, ack it, wait for IDLE
    task automatic p1_put_ack(input string nm, input logic [7:0] c);
        @(negedge clk);
        p1_cor = c; p1_bomb_cap = 3'd4; bomb_num_p1 = 3'd0; p1_btn = 1'b1;
        repeat (3) @(negedge clk);
        chk({nm, "_put"}, {23'd0, p1_put, p1_put_cor}, {23'd0, 1'b1, c});
        set_tile(c, 3'd2);
        wait_idle({nm, "_idle"}, 40);
        p1_btn = 1'b0;
    endtask

    typedef struct {
        logic [2:0] cap;
        logic [2:0] num;
        logic [2:0] tile;
        logic [7:0] cor;
        logic       exp_put;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vt [8];
    vec_t v;
    int   bcnt, np, cyc;
    int   exp_p1_cnt;

    initial begin
        reset_n = 1'b0;
        p1_btn = 0; p2_btn = 0; p1_cor = 0; p2_cor = 0;
        p1_bomb_cap = 0; p2_bomb_cap = 0; bomb_num_p1 = 0; bomb_num_p2 = 0;
        tiles = '0;
        exp_p1_cnt = 0;

        vt[0] = '{3'd1, 3'd0, 3'd0, 8'h22, 1'b1, 2'd0};
        vt[1] = '{3'd2, 3'd2, 3'd0, 8'h23, 1'b0, 2'd0};
        vt[2] = '{3'd7, 3'd4, 3'd0, 8'h24, 1'b0, 2'd0};
        vt[3] = '{3'd7, 3'd3, 3'd0, 8'h25, 1'b1, 2'd0};
        vt[4] = '{3'd1, 3'd0, 3'd7, 8'h10, 1'b0, 2'd1};
        vt[5] = '{3'd0, 3'd1, 3'd7, 8'h11, 1'b0, 2'd0};
        vt[6] = '{3'd4, 3'd3, 3'd2, 8'hFF, 1'b0, 2'd1};
        vt[7] = '{3'd4, 3'd0, 3'd0, 8'h00, 1'b1, 2'd0};

        repeat (3) @(negedge clk);
        chk("rst_outs_a", {8'd0, p1_put, p2_put, p1_put_cor, p2_put_cor, p1_reject, p2_reject,
                           p1_rej_code, p2_rej_code}, 32'd0);
        chk("rst_outs_b", {22'd0, p1_busy, p2_busy, p1_put_cnt, p2_put_cnt}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // ---------------- table-driven P1 presses ----------------
        for (int i = 0; i < 8; i++) begin
            v = vt[i];
            @(negedge clk);
            tiles = '0;
            set_tile(v.cor, v.tile);
            p1_cor = v.cor; p1_bomb_cap = v.cap; bomb_num_p1 = v.num; p1_btn = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d_busy_check", i), p1_busy, 1);
            bcnt = 1;
            @(negedge clk);
            chk($sformatf("v%0d_reject", i), p1_reject, !v.exp_put);
            chk($sformatf("v%0d_noput_early", i), p1_put, 0);
            if (!v.exp_put) begin
                chk($sformatf("v%0d_code", i), p1_rej_code, v.exp_code);
                chk($sformatf("v%0d_busy_after_rej", i), p1_busy, 0);
            end else begin
                if (p1_busy) bcnt++;
                @(negedge clk);
                chk($sformatf("v%0d_put", i), p1_put, 1);
                chk($sformatf("v%0d_put_cor", i), p1_put_cor, v.cor);
                if (p1_busy) bcnt++;
                set_tile(v.cor, 3'd2);
                cyc = 0;
                while (cyc < 100) begin
                    @(negedge clk);
                    cyc++;
                    if (!p1_busy) break;
                    bcnt++;
                end
                exp_p1_cnt++;
                chk($sformatf("v%0d_busy_len", i), bcnt, 18);
                chk($sformatf("v%0d_put_cnt", i), p1_put_cnt, exp_p1_cnt);
            end
            p1_btn = 1'b0;
        end

        // ---------------- P2 occupied cell ----------------
        @(negedge clk);
        tiles = '0; set_tile(8'h50, 3'd7);
        p2_cor = 8'h50; p2_bomb_cap = 3'd4; bomb_num_p2 = 3'd0; p2_btn = 1'b1;
        repeat (2) @(negedge clk);
        chk("p2_occ_reject", {p2_reject, p2_rej_code, p2_put}, {1'b1, 2'd1, 1'b0});
        p2_btn = 1'b0;

        // ---------------- P2 ack timeout ----------------
        @(negedge clk);
        tiles = '0;
        p2_cor = 8'h30; p2_btn = 1'b1;
        repeat (3) @(negedge clk);
        chk("p2_tmo_put", {p2_put, p2_put_cor}, {1'b1, 8'h30});
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (j < 4) chk($sformatf("p2_tmo_early%0d", j), p2_reject, 0);
            else       chk("p2_tmo_reject", {p2_reject, p2_rej_code}, {1'b1, 2'd3});
        end
        cyc = 0;
        while (p2_busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("p2_tmo_cooldown_len", cyc, 15);
        chk("p2_tmo_cnt", p2_put_cnt, 0);
        p2_btn = 1'b0;

        // ---------------- same-cell arbitration ----------------
        @(negedge clk);
        tiles = '0;
        p1_cor = 8'h45; p2_cor = 8'h45; p1_bomb_cap = 3'd4; bomb_num_p1 = 3'd0;
        p1_btn = 1'b1; p2_btn = 1'b1;
        repeat (3) @(negedge clk);
        chk("arb_p1_put", {p1_put, p1_put_cor}, {1'b1, 8'h45});
        chk("arb_p2_reject", {p2_put, p2_reject, p2_rej_code}, {1'b0, 1'b1, 2'd2});
        chk("arb_p2_idle", p2_busy, 0);
        set_tile(8'h45, 3'd2);
        wait_idle("arb_idle", 40);
        exp_p1_cnt++;
        chk("arb_cnts", {p1_put_cnt, p2_put_cnt}, {4'(exp_p1_cnt), 4'd0});
        p1_btn = 1'b0; p2_btn = 1'b0;

        // ---------------- different cells same cycle ----------------
        @(negedge clk);
        p1_cor = 8'h46; p2_cor = 8'h47;
        p1_btn = 1'b1; p2_btn = 1'b1;
        repeat (3) @(negedge clk);
        chk("diff_both_put", {p1_put, p2_put, p2_reject}, {1'b1, 1'b1, 1'b0});
        set_tile(8'h46, 3'd2); set_tile(8'h47, 3'd2);
        wait_idle("diff_idle", 40);
        exp_p1_cnt++;
        chk("diff_cnts", {p1_put_cnt, p2_put_cnt}, {4'(exp_p1_cnt), 4'd1});
        p1_btn = 1'b0; p2_btn = 1'b0;

        // ---------------- held button ----------------
        @(negedge clk);
        tiles = '0;
        p1_cor = 8'h60; p1_btn = 1'b1;
        np = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (p1_put) begin
                np++;
                set_tile(8'h60, 3'd2);
            end
        end
        exp_p1_cnt++;
        chk("held_one_put", np, 1);
        chk("held_cnt", p1_put_cnt, exp_p1_cnt);
        p1_btn = 1'b0;

        // ---------------- press during cooldown is dropped ----------------
        @(negedge clk);
        p1_cor = 8'h61; p1_btn = 1'b1;
        repeat (3) @(negedge clk);
        chk("cd_first_put", p1_put, 1);
        set_tile(8'h61, 3'd2);
        @(negedge clk); p1_btn = 1'b0;
        @(negedge clk); p1_btn = 1'b1;
        p1_cor = 8'h62;
        np = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (p1_put) np++;
        end
        exp_p1_cnt++;
        chk("cd_press_ignored", np, 0);
        chk("cd_idle", p1_busy, 0);
        p1_btn = 1'b0;
        p1_put_ack("after_cd", 8'h62);
        exp_p1_cnt++;
        chk("after_cd_cnt", p1_put_cnt, exp_p1_cnt);

        // ---------------- reset during WAIT_ACK ----------------
        @(negedge clk);
        p1_cor = 8'h70; p1_btn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pre_put", p1_put, 1);
        #2 reset_n = 1'b0; p1_btn = 1'b0;
        #1;
        chk("rst_mid_a", {8'd0, p1_put, p2_put, p1_put_cor, p2_put_cor, p1_reject, p2_reject,
                          p1_rej_code, p2_rej_code}, 32'd0);
        chk("rst_mid_b", {22'd0, p1_busy, p2_busy, p1_put_cnt, p2_put_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_release%0d", k), {p1_put, p1_busy, p1_reject}, 3'd0);
        end

        // ---------------- put counter saturation ----------------
        tiles = '0;
        for (int k = 0; k < 16; k++) begin
            p1_put_ack($sformatf("sat%0d", k), 8'(8'h80 + k));
            if (k == 14) chk("sat_cnt15", p1_put_cnt, 15);
        end
        chk("sat_cnt_hold", p1_put_cnt, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
